// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_t     : arbiter FSM states (binary encoded)
//   OWN_CPU/DMA : encoding of the requester that owns the in-flight access
//   grant_owner : maps a one-hot grant {dma, cpu} to an owner code
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Grant vector layout: bit 0 = CPU, bit 1 = DMA.
  function automatic logic grant_owner(input logic [1:0] grant);
    return grant[1] ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   i_clock, i_reset  : clock, synchronous active-high reset
//   i_req_cpu/dma     : requests
//   i_accept          : the caller takes the current grant; updates last_grant
//   o_grant           : one-hot grant {dma, cpu}, combinational
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_req_cpu,
  input  logic       i_req_dma,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  // On a tie the requester that was not served last wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_req_cpu && i_req_dma) begin
      o_grant = (r_last_grant == OWN_DMA) ? 2'b01 : 2'b10;
    end else if (i_req_cpu) begin
      o_grant = 2'b01;
    end else if (i_req_dma) begin
      o_grant = 2'b10;
    end
  end

  // Reset to DMA so the CPU wins the first tie.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last_grant <= OWN_DMA;
    end else if (i_accept && (o_grant != 2'b00)) begin
      r_last_grant <= grant_owner(o_grant);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing a single-ported memory between the CPU memory stage and a
// DMA/program-loader port. Each access: grant in IDLE, one ACCESS cycle on
// the memory, one RESP cycle pulsing the owner's ready.
// Ports:
//   i_clock, i_reset            : clock, synchronous active-high reset
//   i_cpu_* / o_cpu_*           : CPU request fields, ready pulse, read data
//   i_dma_* / o_dma_*           : DMA request fields, ready pulse, read data
//   o_mem_we/addr/wdata         : memory control (addr/wdata hold last latched)
//   i_mem_rdata                 : memory read data, combinational from o_mem_addr
//   o_busy                      : high in ACCESS and RESP
//
// state     | meaning
// ST_IDLE   | waiting for a request; grant and latch winner's fields
// ST_ACCESS | memory driven with latched access, read data captured at end
// ST_RESP   | owner's ready pulses with captured data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic              o_dma_ready,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic [1:0]        w_grant;

  logic              r_we;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_ready;
  logic              r_dma_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_busy;

  rr_arbiter2 u_rr (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req_cpu (i_cpu_req),
    .i_req_dma (i_dma_req),
    .i_accept  (w_accept),
    .o_grant   (w_grant)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          w_accept     = 1'b1;
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // The read data is captured straight into the owner's rdata register at the
  // end of ACCESS, so it appears together with the ready pulse in RESP and the
  // other requester's rdata keeps its previous value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_we        <= 1'b0;
      r_owner     <= OWN_CPU;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      if (w_accept) begin
        r_owner <= grant_owner(w_grant);
        if (w_grant[1]) begin
          r_we    <= i_dma_we;
          r_addr  <= i_dma_addr;
          r_wdata <= i_dma_wdata;
        end else begin
          r_we    <= i_cpu_we;
          r_addr  <= i_cpu_addr;
          r_wdata <= i_cpu_wdata;
        end
      end
      if (r_state == ST_ACCESS) begin
        if (r_owner == OWN_CPU) begin
          r_cpu_ready <= 1'b1;
          r_cpu_rdata <= i_mem_rdata;
        end else begin
          r_dma_ready <= 1'b1;
          r_dma_rdata <= i_mem_rdata;
        end
      end
      r_busy <= (w_next_state != ST_IDLE);
    end
  end

  // Gated by reset so a reset landing on the ACCESS cycle cancels the write.
  assign o_mem_we    = (r_state == ST_ACCESS) && r_we && !i_reset;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_dma_ready = r_dma_ready;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dma_rdata = r_dma_rdata;
  assign o_busy      = r_busy;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter for the single-ported combined instruction/data memory of the multicycle CPU. It shares the memory between the CPU's memory stage and a DMA/program-loader port, using round-robin arbitration and a request/ready handshake. It sits between both requesters and the memory, and owns the memory's write-enable, address and write-data inputs. Each access is latched at grant, performed in one memory cycle, and answered with a one-cycle `ready` pulse carrying read data.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 16: memory word width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request; held high until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read; valid while `cpu_req`.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_ready`.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ready`, `dma_rdata`: same as the `cpu_*` ports, for the DMA port.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; combinational from `mem_addr`.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- **States:** IDLE, ACCESS, RESP. The state register is binary encoded.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that was not granted last (`last_grant` flag).
  - On grant: register `we`, `addr` and `wdata` of the winner, record the winner as `owner`, update `last_grant`, go to ACCESS.
- **ACCESS (exactly one cycle):**
  - `mem_addr` = latched address.
  - `mem_we` = latched `we`.
  - `mem_wdata` = latched write data.
  - At the end of the cycle, capture `mem_rdata` into the response register. The capture happens for writes too; the value is then don't-care.
  - Go to RESP.
- **RESP (exactly one cycle):**
  - Pulse the owner's `ready`; present the captured data on the owner's `rdata`.
  - The non-owner's `ready` stays 0.
  - Go to IDLE.
- **Requester contract:**
  - A requester must hold `req` and its fields stable until it sees `ready`.
  - A requester must drop `req` in the cycle after `ready`, or keep it high to request again.
  - The arbiter ignores field changes after the grant, because the fields are latched.
- **Signals outside ACCESS:** `mem_we` = 0; `mem_addr` and `mem_wdata` hold their last latched values. Only `mem_we` is functionally significant there.
- **`rdata` outputs:** hold their last value between pulses.
- **`req` dropped after grant:** the access still completes and `ready` still pulses. This is a contract violation, but the arbiter keeps no error state for it.
- **Reset (any state, including mid-access):**
  - State goes to IDLE.
  - `cpu_ready`, `dma_ready`, `mem_we` and `busy` = 0.
  - `cpu_rdata`, `dma_rdata`, `mem_addr` and `mem_wdata` = 0.
  - `last_grant` = DMA, so the CPU wins the first tie.
  - An in-flight access is abandoned with no `ready` pulse. If reset is asserted during the ACCESS cycle, the write is suppressed: `mem_we` is gated by `!reset`.

## Timing
- `req` sampled high in IDLE at cycle N:
  - Memory is driven in cycle N+1.
  - `ready` and `rdata` are valid in cycle N+2.
  - IDLE is re-entered at N+3.
- Throughput: one access per 3 cycles. Under continuous contention the requesters strictly alternate.
- Worst-case wait for a requester: 3 cycles (one foreign access) before its own grant.
- No combinational path from any `req` or field input to any output. All outputs are registered, except `mem_we`, which is decoded from state plus the latched `we` and gated by `reset`.
- A write takes effect at the rising edge that ends ACCESS.

## Structure
- Shared package `mem_arb_pkg`: state encoding constants (`ST_IDLE`=2'd0, `ST_ACCESS`=2'd1, `ST_RESP`=2'd2), and owner encoding (`OWN_CPU`=1'b0, `OWN_DMA`=1'b1).
- One natural sub-module, `rr_arbiter2`: two requests plus the `last_grant` flag in, one-hot grant out, updating `last_grant` on an accept strobe. Everything else stays in the top.
- No FIFO. Requests are not queued beyond the single latched access.

## Test plan
- **Reset mid-access:** DMA write of 16'h00FF to 8'h20 from IDLE; assert reset on the ACCESS cycle. Required: `mem_we` never high, `dma_ready` never pulses, memory[8'h20] unchanged, all outputs 0 the cycle after reset.
- **Lone CPU read:** memory[8'h10] = 16'hBEEF; `cpu_req` with `cpu_we`=0, address 8'h10, starting at cycle N. Required: `mem_addr`=8'h10 in N+1; `cpu_ready`=1 and `cpu_rdata`=16'hBEEF in N+2 only; `dma_ready`=0 throughout.
- **Tie after reset:** both requesters request in the same cycle directly after reset. Required: CPU is granted first; DMA is served 3 cycles later; `ready` pulses at N+2 and N+5.
- **Write then read-back:** DMA writes 16'h1234 to 8'h3F, then the CPU reads 8'h3F. Required: `mem_we` is high for exactly 1 cycle; `cpu_rdata`=16'h1234.
- **Continuous contention:** both requesters hold `req` for 12 cycles. Required: grant order DMA, CPU, DMA, CPU (last grant was the CPU before the window); four `ready` pulses total, each separated by 3 cycles.
- **Field change after grant:** CPU changes `cpu_addr` from 8'h05 to 8'h06 in the ACCESS cycle. Required: `mem_addr` stays 8'h05; returned data is memory[8'h05].
